// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Access-size encoding, FSM states and lane widths.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_e;

    localparam int BYTE_W  = 8;
    localparam int HALF_W  = 16;
    localparam int WORD_W  = 32;
    localparam int DWORD_W = 64;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit.
// Byte enables, store replication, load extraction and extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8,
    parameter int LB   = $clog2(NB)
) (
    input  size_e            size,
    input  logic [LB-1:0]    lane,
    input  logic             uns,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [NB-1:0]    be,
    output logic [XLEN-1:0]  wdata_rep,
    output logic [XLEN-1:0]  rdata_ext
);

    logic [XLEN-1:0] sh;

    // Bring the addressed lane down to bit 0
    assign sh = rdata >> {lane, 3'b000};

    // Per-size enables, replication and extension
    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        rdata_ext = sh;
        unique case (size)
            SZ_B: begin
                be        = NB'(1) << lane;
                wdata_rep = {(XLEN/BYTE_W){wdata[BYTE_W-1:0]}};
                rdata_ext = uns ? XLEN'(sh[BYTE_W-1:0])
                                : XLEN'($signed(sh[BYTE_W-1:0]));
            end
            SZ_H: begin
                be        = NB'(3) << lane;
                wdata_rep = {(XLEN/HALF_W){wdata[HALF_W-1:0]}};
                rdata_ext = uns ? XLEN'(sh[HALF_W-1:0])
                                : XLEN'($signed(sh[HALF_W-1:0]));
            end
            SZ_W: begin
                be        = NB'(15) << lane;
                wdata_rep = {(XLEN/WORD_W){wdata[WORD_W-1:0]}};
                rdata_ext = uns ? XLEN'(sh[WORD_W-1:0])
                                : XLEN'($signed(sh[WORD_W-1:0]));
            end
            SZ_D: begin
                be        = '1;
                wdata_rep = wdata;
                rdata_ext = sh;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller.
// Accepts one core request, runs one bus access, returns one response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [XLEN/8-1:0]     mem_be,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  we_q;
    size_e                 size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       rdata_q;
    logic                  err_q;
    logic [15:0]           cnt_q;
    logic                  bad;
    logic                  tmo;
    logic [NB-1:0]         be;
    logic [XLEN-1:0]       wdata_rep;
    logic [XLEN-1:0]       rdata_ext;

    assign tmo = (cnt_q == CNT_LAST);

    // Flag misaligned or unsupported sizes on the incoming request
    always_comb begin
        bad = 1'b0;
        unique case (size_e'(req_size))
            SZ_B: bad = 1'b0;
            SZ_H: bad = req_addr[0];
            SZ_W: bad = |req_addr[1:0];
            SZ_D: bad = (XLEN != 64) || (|req_addr[2:0]);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; an ack beats a simultaneous timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = bad ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (mem_ack || tmo) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, wait counter and response status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == S_IDLE && req_valid) begin
            we_q    <= req_we;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= bad;
            cnt_q   <= '0;
        end else if (state_q == S_ACCESS) begin
            if (mem_ack) begin
                rdata_q <= mem_rdata;
                err_q   <= 1'b0;
            end else if (tmo) begin
                err_q   <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + 16'd1;
            end
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size      (size_q),
        .lane      (addr_q[LB-1:0]),
        .uns       (uns_q),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // FSM outputs; bus and response fields are zero when not active
    always_comb begin
        req_ready = (state_q == S_IDLE);
        stall     = (state_q != S_IDLE) || req_valid;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (state_q == S_ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            mem_wdata = wdata_rep;
            mem_be    = be;
        end
        if (state_q == S_RESP) begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!err_q && !we_q) rsp_rdata = rdata_ext;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl (XLEN=32, TIMEOUT=4).
// Directed vectors; expected responses queued, checked by a monitor.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu_ctrl #(
        .XLEN       (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int vecs  = 0;
    int fails = 0;
    int cyc   = 0;

    int          mem_dly  = -1;
    logic [31:0] mem_data = '0;
    logic [31:0] x_addr   = '0;
    logic [3:0]  x_be     = '0;
    logic [31:0] x_wd     = '0;
    logic        x_we     = 1'b0;
    logic        stray    = 1'b0;
    int          acc      = 0;
    int          mem_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder; also checks bus fields every access cycle
    always @(negedge clk) begin
        if (mem_req) begin
            chk("mem_addr", 64'(mem_addr), 64'(x_addr));
            chk("mem_be", 64'(mem_be), 64'(x_be));
            chk("mem_wdata", 64'(mem_wdata), 64'(x_wd));
            chk("mem_we", 64'(mem_we), 64'(x_we));
            mem_ack   = (acc == mem_dly);
            mem_rdata = mem_ack ? mem_data : 32'h0;
            acc++;
            mem_seen++;
        end else begin
            acc       = 0;
            mem_ack   = stray;
            mem_rdata = 32'h0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                vecs++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("mem_req_in_resp", 64'(mem_req), 64'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic issue(
        input logic we, input logic [1:0] sz, input logic uns,
        input logic [31:0] addr, input logic [31:0] wd,
        input logic [31:0] md, input int dly,
        input logic [31:0] e_rd, input logic e_err, input int lat,
        input logic [31:0] e_ma, input logic [3:0] e_be,
        input logic [31:0] e_wd);
        exp_t e;
        @(negedge clk);
        wait_ready();
        mem_dly  = dly;
        mem_data = md;
        x_addr   = e_ma;
        x_be     = e_be;
        x_wd     = e_wd;
        x_we     = we;
        mem_seen = 0;
        e.rd  = e_rd;
        e.err = e_err;
        e.cyc = cyc + lat;
        sb.push_back(e);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_drain();
        chk("mem_used", 64'(mem_seen != 0), 64'(lat != 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int c;
        exp_t e;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_mem_ctl", 64'({mem_req, mem_we, mem_be}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;

        // we sz uns addr wd md dly | rd err lat | maddr be mwdata
        issue(1, 2'b00, 0, 32'h13, 32'h000000AB, 32'h0, 0,
              32'h0, 0, 2, 32'h10, 4'b1000, 32'hABABABAB);
        issue(0, 2'b01, 0, 32'h22, 32'h12345678, 32'h80010000, 1,
              32'hFFFF8001, 0, 3, 32'h20, 4'b1100, 32'h56785678);
        issue(0, 2'b01, 1, 32'h22, 32'h12345678, 32'h80010000, 1,
              32'h00008001, 0, 3, 32'h20, 4'b1100, 32'h56785678);
        issue(0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 0,
              32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
        issue(0, 2'b00, 0, 32'h01, 32'h0, 32'h0000F000, 0,
              32'hFFFFFFF0, 0, 2, 32'h0, 4'b0010, 32'h0);
        issue(0, 2'b00, 1, 32'h03, 32'h0, 32'h7F000000, 2,
              32'h0000007F, 0, 4, 32'h0, 4'b1000, 32'h0);
        issue(0, 2'b00, 0, 32'h02, 32'h0, 32'h00800000, 0,
              32'hFFFFFF80, 0, 2, 32'h0, 4'b0100, 32'h0);
        issue(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h11111111, 0,
              32'h0, 0, 2, 32'h40, 4'b1111, 32'hDEADBEEF);
        issue(1, 2'b01, 0, 32'h2E, 32'h0000BEEF, 32'h0, 1,
              32'h0, 0, 3, 32'h2C, 4'b1100, 32'hBEEFBEEF);
        issue(0, 2'b11, 0, 32'h08, 32'h0, 32'h0, 0,
              32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
        issue(0, 2'b01, 0, 32'h05, 32'h0, 32'h0, 0,
              32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
        issue(1, 2'b01, 0, 32'h01, 32'h1234, 32'h0, 0,
              32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
        issue(0, 2'b10, 0, 32'h100, 32'h0, 32'hFFFFFFFF, -1,
              32'h0, 1, 5, 32'h100, 4'b1111, 32'h0);
        issue(0, 2'b10, 0, 32'h104, 32'h0, 32'hCAFEBABE, 3,
              32'hCAFEBABE, 0, 5, 32'h104, 4'b1111, 32'h0);
        issue(0, 2'b10, 1, 32'h08, 32'h0, 32'h80000000, 0,
              32'h80000000, 0, 2, 32'h08, 4'b1111, 32'h0);
        issue(0, 2'b01, 0, 32'h20, 32'h0, 32'h12347FFF, 0,
              32'h00007FFF, 0, 2, 32'h20, 4'b0011, 32'h0);

        // Reset during an access
        @(negedge clk);
        wait_ready();
        mem_dly      = -1;
        x_addr       = 32'h200;
        x_be         = 4'b1111;
        x_wd         = 32'h0;
        x_we         = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h200;
        req_wdata    = 32'h0;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_mem_req_before", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mem_req", 64'(mem_req), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        chk("stray_ready", 64'(req_ready), 64'd1);

        // Back-to-back with req_valid held
        @(negedge clk);
        wait_ready();
        c            = cyc;
        mem_dly      = 0;
        mem_data     = 32'h0;
        x_addr       = 32'h0;
        x_be         = 4'b0010;
        x_wd         = 32'h5A5A5A5A;
        x_we         = 1'b1;
        e.rd  = 32'h0;
        e.err = 1'b0;
        e.cyc = c + 2;
        sb.push_back(e);
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h01;
        req_wdata    = 32'h0000005A;
        req_valid    = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k == 2) begin
                chk("b2b_ready_resp", 64'(req_ready), 64'd0);
                mem_data     = 32'h00AB0000;
                x_addr       = 32'h80;
                x_be         = 4'b0100;
                x_wd         = 32'h0;
                x_we         = 1'b0;
                e.rd  = 32'hFFFFFFAB;
                e.err = 1'b0;
                e.cyc = c + 5;
                sb.push_back(e);
                req_we       = 1'b0;
                req_addr     = 32'h82;
                req_wdata    = 32'h0;
            end
            if (k == 4) req_valid = 1'b0;
            #1 chk("b2b_stall", 64'(stall), 64'd1);
            @(negedge clk);
        end
        wait_drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
